multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_ctrl                                              |
// | Description : Control FSM for a multicycle RV32I-subset datapath.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        branch_taken,
    output logic        imem_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_a_sel,
    output logic        alu_b_sel,
    output logic        dmem_re,
    output logic        dmem_we,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    localparam logic [2:0] c_FETCH  = 3'd0;
    localparam logic [2:0] c_DECODE = 3'd1;
    localparam logic [2:0] c_EXEC   = 3'd2;
    localparam logic [2:0] c_MEM    = 3'd3;
    localparam logic [2:0] c_WB     = 3'd4;
    localparam logic [2:0] c_TRAP   = 3'd5;

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [2:0] c_F3_WORD   = 3'b010;

    logic [2:0]  r_state;
    logic        r_illegal;
    logic [31:0] r_instret;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rd;
    logic        w_unused;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_branch;
    logic        w_is_jal;
    logic        w_is_jalr;
    logic        w_legal;
    logic [1:0]  w_a_sel;
    logic        w_b_sel;

    logic        w_imem_req;
    logic        w_ir_we;
    logic        w_pc_we;
    logic [1:0]  w_pc_src;
    logic [1:0]  w_alu_a_sel;
    logic        w_alu_b_sel;
    logic        w_dmem_re;
    logic        w_dmem_we;
    logic        w_reg_we;
    logic [1:0]  w_wb_sel;

    assign w_opcode    = instruction[6:0];
    assign w_rd        = instruction[11:7];
    assign w_funct3    = instruction[14:12];
    assign w_unused    = ^instruction[31:15];

    assign w_is_load   = (w_opcode == c_OP_LOAD);
    assign w_is_store  = (w_opcode == c_OP_STORE);
    assign w_is_branch = (w_opcode == c_OP_BRANCH);
    assign w_is_jal    = (w_opcode == c_OP_JAL);
    assign w_is_jalr   = (w_opcode == c_OP_JALR);

    always_comb begin
        w_legal = 1'b0;
        case (w_opcode)
            c_OP_R, c_OP_IMM, c_OP_BRANCH, c_OP_JAL,
            c_OP_JALR, c_OP_LUI, c_OP_AUIPC:  w_legal = 1'b1;
            c_OP_LOAD, c_OP_STORE:            w_legal = (w_funct3 == c_F3_WORD);
            default:                          w_legal = 1'b0;
        endcase
    end

    // Operand selects depend only on the opcode, so they stay stable from EXEC through WB.
    assign w_b_sel = !((w_opcode == c_OP_R) || w_is_branch);
    assign w_a_sel = (w_opcode == c_OP_LUI)                   ? 2'd2 :
                     ((w_opcode == c_OP_AUIPC) || w_is_jal)   ? 2'd1 : 2'd0;

    always_comb begin
        w_imem_req  = 1'b0;
        w_ir_we     = 1'b0;
        w_pc_we     = 1'b0;
        w_pc_src    = 2'd0;
        w_alu_a_sel = 2'd0;
        w_alu_b_sel = 1'b0;
        w_dmem_re   = 1'b0;
        w_dmem_we   = 1'b0;
        w_reg_we    = 1'b0;
        w_wb_sel    = 2'd0;
        case (r_state)
            c_FETCH: begin
                w_imem_req = 1'b1;
                w_ir_we    = imem_ready;
            end
            c_EXEC: begin
                w_alu_a_sel = w_a_sel;
                w_alu_b_sel = w_b_sel;
                if (w_is_branch) begin
                    w_pc_we  = 1'b1;
                    w_pc_src = branch_taken ? 2'd1 : 2'd0;
                end
            end
            c_MEM: begin
                w_alu_a_sel = w_a_sel;
                w_alu_b_sel = w_b_sel;
                w_dmem_re   = w_is_load;
                w_dmem_we   = w_is_store;
                w_pc_we     = w_is_store && dmem_ready;
            end
            c_WB: begin
                w_alu_a_sel = w_a_sel;
                w_alu_b_sel = w_b_sel;
                w_reg_we    = (w_rd != 5'd0);
                w_pc_we     = 1'b1;
                w_pc_src    = w_is_jal ? 2'd1 : (w_is_jalr ? 2'd2 : 2'd0);
                w_wb_sel    = w_is_load ? 2'd1 : ((w_is_jal || w_is_jalr) ? 2'd2 : 2'd0);
            end
            default: begin
            end
        endcase
    end

    // Reset squashes every side effect within the same cycle, so an aborted access writes nothing.
    assign imem_req  = w_imem_req  & ~rst;
    assign ir_we     = w_ir_we     & ~rst;
    assign pc_we     = w_pc_we     & ~rst;
    assign pc_src    = rst ? 2'd0  : w_pc_src;
    assign alu_a_sel = rst ? 2'd0  : w_alu_a_sel;
    assign alu_b_sel = w_alu_b_sel & ~rst;
    assign dmem_re   = w_dmem_re   & ~rst;
    assign dmem_we   = w_dmem_we   & ~rst;
    assign reg_we    = w_reg_we    & ~rst;
    assign wb_sel    = rst ? 2'd0  : w_wb_sel;
    assign illegal   = r_illegal   & ~rst;
    assign instret   = rst ? 32'd0 : r_instret;
    assign state     = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_FETCH;
            r_illegal <= 1'b0;
            r_instret <= 32'd0;
        end else begin
            if (w_pc_we) begin
                r_instret <= r_instret + 32'd1;
            end
            case (r_state)
                c_FETCH: begin
                    if (imem_ready) begin
                        r_state <= c_DECODE;
                    end
                end
                c_DECODE: begin
                    if (w_legal) begin
                        r_state <= c_EXEC;
                    end else begin
                        r_state   <= c_TRAP;
                        r_illegal <= 1'b1;
                    end
                end
                c_EXEC: begin
                    if (w_is_branch) begin
                        r_state <= c_FETCH;
                    end else if (w_is_load || w_is_store) begin
                        r_state <= c_MEM;
                    end else begin
                        r_state <= c_WB;
                    end
                end
                c_MEM: begin
                    if (dmem_ready) begin
                        r_state <= w_is_load ? c_WB : c_FETCH;
                    end
                end
                c_WB: begin
                    r_state <= c_FETCH;
                end
                c_TRAP: begin
                    r_state <= c_TRAP;
                end
                default: begin
                    r_state <= c_FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_multicycle_ctrl                                           |
// | Description : Directed self-checking bench for multicycle_ctrl.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic        imem_ready;
    logic        dmem_ready;
    logic        branch_taken;
    logic        imem_req;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic [1:0]  alu_a_sel;
    logic        alu_b_sel;
    logic        dmem_re;
    logic        dmem_we;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        illegal;
    logic [2:0]  state;
    logic [31:0] instret;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_ctrl u_dut (
        .clk          (clk),
        .rst          (rst),
        .instruction  (instruction),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .branch_taken (branch_taken),
        .imem_req     (imem_req),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .dmem_re      (dmem_re),
        .dmem_we      (dmem_we),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .illegal      (illegal),
        .state        (state),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    // Starts in a FETCH cycle; returns just after the edge that leaves DECODE.
    task automatic fetch_decode(input logic [31:0] instr);
        instruction = instr;
        imem_ready  = 1'b1;
        settle;
        check_value("fetch_state", state, 32'd0);
        check_value("fetch_imem_req", imem_req, 32'd1);
        check_value("fetch_ir_we", ir_we, 32'd1);
        tick;
        imem_ready = 1'b0;
        settle;
        check_value("decode_state", state, 32'd1);
        check_value("decode_imem_req", imem_req, 32'd0);
        tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        instruction  = 32'd0;
        imem_ready   = 1'b0;
        dmem_ready   = 1'b0;
        branch_taken = 1'b0;
        tick;
        tick;
        settle;
        check_value("rst_state", state, 32'd0);
        check_value("rst_imem_req", imem_req, 32'd0);
        check_value("rst_instret", instret, 32'd0);
        check_value("rst_illegal", illegal, 32'd0);
        rst = 1'b0;
        settle;
        check_value("post_rst_imem_req", imem_req, 32'd1);

        // ADDI x1, x0, 5
        fetch_decode(32'h00500093);
        settle;
        check_value("addi_exec_state", state, 32'd2);
        check_value("addi_exec_bsel", alu_b_sel, 32'd1);
        check_value("addi_exec_pc_we", pc_we, 32'd0);
        tick;
        settle;
        check_value("addi_wb_state", state, 32'd4);
        check_value("addi_wb_reg_we", reg_we, 32'd1);
        check_value("addi_wb_bsel", alu_b_sel, 32'd1);
        check_value("addi_wb_wb_sel", wb_sel, 32'd0);
        check_value("addi_wb_pc_src", pc_src, 32'd0);
        check_value("addi_wb_pc_we", pc_we, 32'd1);
        check_value("addi_wb_instret", instret, 32'd0);
        tick;
        settle;
        check_value("addi_done_state", state, 32'd0);
        check_value("addi_done_instret", instret, 32'd1);

        // LW x2, 0(x1), data ready in the third MEM cycle
        fetch_decode(32'h0000A103);
        settle;
        check_value("lw_exec_state", state, 32'd2);
        tick;
        for (int i = 0; i < 3; i++) begin
            dmem_ready = (i == 2);
            settle;
            check_value("lw_mem_state", state, 32'd3);
            check_value("lw_mem_re", dmem_re, 32'd1);
            check_value("lw_mem_we", dmem_we, 32'd0);
            check_value("lw_mem_pc_we", pc_we, 32'd0);
            tick;
        end
        dmem_ready = 1'b0;
        settle;
        check_value("lw_wb_state", state, 32'd4);
        check_value("lw_wb_wb_sel", wb_sel, 32'd1);
        check_value("lw_wb_reg_we", reg_we, 32'd1);
        check_value("lw_wb_re", dmem_re, 32'd0);
        tick;
        settle;
        check_value("lw_done_instret", instret, 32'd2);

        // BEQ x0, x0, +8
        branch_taken = 1'b1;
        fetch_decode(32'h00000463);
        settle;
        check_value("beq_exec_state", state, 32'd2);
        check_value("beq_exec_pc_we", pc_we, 32'd1);
        check_value("beq_exec_pc_src", pc_src, 32'd1);
        check_value("beq_exec_reg_we", reg_we, 32'd0);
        check_value("beq_exec_bsel", alu_b_sel, 32'd0);
        branch_taken = 1'b0;
        settle;
        check_value("beq_nt_pc_src", pc_src, 32'd0);
        check_value("beq_nt_pc_we", pc_we, 32'd1);
        branch_taken = 1'b1;
        tick;
        settle;
        check_value("beq_done_state", state, 32'd0);
        check_value("beq_done_instret", instret, 32'd3);
        branch_taken = 1'b0;

        // JALR x1, 0(x1)
        fetch_decode(32'h000080E7);
        tick;
        settle;
        check_value("jalr_wb_state", state, 32'd4);
        check_value("jalr_wb_pc_src", pc_src, 32'd2);
        check_value("jalr_wb_wb_sel", wb_sel, 32'd2);
        check_value("jalr_wb_reg_we", reg_we, 32'd1);
        check_value("jalr_wb_bsel", alu_b_sel, 32'd1);
        check_value("jalr_wb_asel", alu_a_sel, 32'd0);
        tick;
        settle;
        check_value("jalr_done_instret", instret, 32'd4);

        // SW x2, 0(x1), data ready immediately
        fetch_decode(32'h0020A023);
        tick;
        dmem_ready = 1'b1;
        settle;
        check_value("sw_mem_state", state, 32'd3);
        check_value("sw_mem_we", dmem_we, 32'd1);
        check_value("sw_mem_re", dmem_re, 32'd0);
        check_value("sw_mem_pc_we", pc_we, 32'd1);
        check_value("sw_mem_pc_src", pc_src, 32'd0);
        check_value("sw_mem_reg_we", reg_we, 32'd0);
        tick;
        dmem_ready = 1'b0;
        settle;
        check_value("sw_done_state", state, 32'd0);
        check_value("sw_done_instret", instret, 32'd5);

        // LUI x1, 1
        fetch_decode(32'h000010B7);
        settle;
        check_value("lui_exec_asel", alu_a_sel, 32'd2);
        check_value("lui_exec_bsel", alu_b_sel, 32'd1);
        tick;
        settle;
        check_value("lui_wb_asel", alu_a_sel, 32'd2);
        check_value("lui_wb_reg_we", reg_we, 32'd1);
        tick;

        // ADDI x0, x0, 0: no register write to x0
        fetch_decode(32'h00000013);
        tick;
        settle;
        check_value("nop_wb_reg_we", reg_we, 32'd0);
        check_value("nop_wb_pc_we", pc_we, 32'd1);
        tick;
        settle;
        check_value("nop_done_state", state, 32'd0);
        check_value("nop_done_instret", instret, 32'd7);

        // Reset while a load is waiting in MEM
        fetch_decode(32'h0000A103);
        tick;
        settle;
        check_value("mrst_pre_re", dmem_re, 32'd1);
        rst = 1'b1;
        settle;
        check_value("mrst_re", dmem_re, 32'd0);
        check_value("mrst_pc_we", pc_we, 32'd0);
        check_value("mrst_reg_we", reg_we, 32'd0);
        check_value("mrst_instret_forced", instret, 32'd0);
        check_value("mrst_state_held", state, 32'd3);
        tick;
        settle;
        check_value("mrst_state", state, 32'd0);
        rst = 1'b0;
        settle;
        check_value("mrst_imem_req", imem_req, 32'd1);
        check_value("mrst_instret", instret, 32'd0);

        // LB (funct3 = 000) is not supported
        fetch_decode(32'h00008103);
        settle;
        check_value("lb_state", state, 32'd5);
        check_value("lb_illegal", illegal, 32'd1);
        rst = 1'b1;
        settle;
        check_value("lb_rst_illegal", illegal, 32'd0);
        tick;
        rst = 1'b0;
        settle;
        check_value("lb_rst_state", state, 32'd0);

        // All-ones word traps and stays trapped
        fetch_decode(32'hFFFFFFFF);
        imem_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            settle;
            check_value("trap_state", state, 32'd5);
            check_value("trap_imem_req", imem_req, 32'd0);
            check_value("trap_illegal", illegal, 32'd1);
            check_value("trap_pc_we", pc_we, 32'd0);
            tick;
        end
        check_value("trap_instret", instret, 32'd0);
        rst = 1'b1;
        settle;
        check_value("trap_rst_illegal", illegal, 32'd0);
        tick;
        rst = 1'b0;
        settle;
        check_value("trap_rst_state", state, 32'd0);
        check_value("trap_rst_imem_req", imem_req, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
